// File: rtl/vram_console_writer.sv
// vram_console_writer: turns a byte stream into VRAM writes for the LCD text
// layer. It keeps a cursor on a COLS x ROWS grid, handles CR/LF/BS, and blanks
// rows and the whole screen. Build option: CONSOLE_CLEAR_ON_RESET_EN makes
// the block clear the whole screen as soon as reset is released.
module vram_console_writer #(
  parameter int          COLS   = 60,
  parameter int          ROWS   = 17,
  parameter int          ADDR_W = 10,
  parameter logic [7:0]  BLANK  = 8'h20
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ch_valid,
  input  logic [7:0]        ch_data,
  output logic              ch_ready,
  input  logic              clr_req,
  output logic [ADDR_W-1:0] v_ada,
  output logic              v_cea,
  output logic [7:0]        v_din,
  output logic [5:0]        cur_col,
  output logic [4:0]        cur_row,
  output logic              busy
);

  typedef enum logic [1:0] {IDLE, CLR_ROW, CLR_ALL} state_t;

  localparam logic [ADDR_W-1:0] COLS_A    = ADDR_W'(COLS);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(COLS * ROWS - 1);
  localparam logic [5:0]        LAST_COL  = 6'(COLS - 1);
  localparam logic [4:0]        LAST_ROW  = 5'(ROWS - 1);

`ifdef CONSOLE_CLEAR_ON_RESET_EN
  localparam state_t RESET_STATE = CLR_ALL;
`else
  localparam state_t RESET_STATE = IDLE;
`endif

  state_t            state_q, state_d;
  logic [5:0]        col_q, col_d;
  logic [4:0]        row_q, row_d;
  logic [ADDR_W-1:0] base_q, base_d;   // row_base: row_q * COLS, kept by stepping
  logic [ADDR_W-1:0] waddr_q, waddr_d; // address walker for the clear sequences
  logic [ADDR_W-1:0] v_ada_q, v_ada_d;
  logic [7:0]        v_din_q, v_din_d;
  logic              v_cea_q, v_cea_d;

  logic [ADDR_W-1:0] cur_addr;
  logic [ADDR_W-1:0] nl_base;
  logic [4:0]        nl_row;
  logic              take_nl;

  assign cur_addr = base_q + ADDR_W'(col_q);

  // Next row and its base address, wrapping the last row back to the top
  always_comb begin
    if (row_q == LAST_ROW) begin
      nl_row  = '0;
      nl_base = '0;
    end else begin
      nl_row  = row_q + 5'd1;
      nl_base = base_q + COLS_A;
    end
  end

  // Next-state logic: byte decode, clear sequencing and the VRAM write port
  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    row_d   = row_q;
    base_d  = base_q;
    waddr_d = waddr_q;
    v_ada_d = v_ada_q;
    v_din_d = v_din_q;
    v_cea_d = 1'b0;
    take_nl = 1'b0;

    if (clr_req) begin
      // Full clear wins over everything, including a pending byte
      state_d = CLR_ALL;
      waddr_d = '0;
      col_d   = '0;
      row_d   = '0;
      base_d  = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (ch_valid) begin
            unique case (ch_data)
              8'h0D: col_d = '0;
              8'h0A: take_nl = 1'b1;
              8'h08: begin
                if (col_q != 6'd0) begin
                  col_d   = col_q - 6'd1;
                  v_cea_d = 1'b1;
                  v_ada_d = cur_addr - ADDR_W'(1);
                  v_din_d = BLANK;
                end
              end
              default: begin
                v_cea_d = 1'b1;
                v_ada_d = cur_addr;
                v_din_d = ch_data;
                if (col_q == LAST_COL) take_nl = 1'b1;
                else                   col_d   = col_q + 6'd1;
              end
            endcase
          end
        end
        CLR_ROW: begin
          v_cea_d = 1'b1;
          v_ada_d = waddr_q;
          v_din_d = BLANK;
          if (waddr_q == base_q + (COLS_A - ADDR_W'(1))) state_d = IDLE;
          else                                           waddr_d = waddr_q + ADDR_W'(1);
        end
        CLR_ALL: begin
          v_cea_d = 1'b1;
          v_ada_d = waddr_q;
          v_din_d = BLANK;
          if (waddr_q == LAST_ADDR) begin
            state_d = IDLE;
            col_d   = '0;
            row_d   = '0;
            base_d  = '0;
          end else begin
            waddr_d = waddr_q + ADDR_W'(1);
          end
        end
        default: state_d = IDLE;
      endcase

      if (take_nl) begin
        col_d   = '0;
        row_d   = nl_row;
        base_d  = nl_base;
        waddr_d = nl_base;
        state_d = CLR_ROW;
      end
    end
  end

  // State and output registers; reset drops any write in flight at once
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RESET_STATE;
      col_q   <= '0;
      row_q   <= '0;
      base_q  <= '0;
      waddr_q <= '0;
      v_ada_q <= '0;
      v_din_q <= '0;
      v_cea_q <= 1'b0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      row_q   <= row_d;
      base_q  <= base_d;
      waddr_q <= waddr_d;
      v_ada_q <= v_ada_d;
      v_din_q <= v_din_d;
      v_cea_q <= v_cea_d;
    end
  end

  assign ch_ready = (state_q == IDLE) && !clr_req;
  assign busy     = (state_q != IDLE);
  assign v_ada    = v_ada_q;
  assign v_din    = v_din_q;
  assign v_cea    = v_cea_q;
  assign cur_col  = col_q;
  assign cur_row  = row_q;

endmodule

// File: tb/tb_vram_console_writer.sv
// tb_vram_console_writer: directed vectors plus hand-written sequences for
// newline clears, row wrap, and clr_req aborting a row clear.
module tb_vram_console_writer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ch_valid;
  logic [7:0] ch_data;
  logic       ch_ready;
  logic       clr_req;
  logic [9:0] v_ada;
  logic       v_cea;
  logic [7:0] v_din;
  logic [5:0] cur_col;
  logic [4:0] cur_row;
  logic       busy;

  int total = 0;
  int bad   = 0;

  vram_console_writer dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .ch_valid (ch_valid),
    .ch_data  (ch_data),
    .ch_ready (ch_ready),
    .clr_req  (clr_req),
    .v_ada    (v_ada),
    .v_cea    (v_cea),
    .v_din    (v_din),
    .cur_col  (cur_col),
    .cur_row  (cur_row),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] data;
    logic       wr;
    logic [9:0] addr;
    logic [7:0] din;
    logic [5:0] col;
    logic [4:0] row;
  } vec_t;

  vec_t vecs [8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Present one byte for one cycle; returns #1 after the accepting edge
  task automatic send(input logic [7:0] d);
    @(negedge clk);
    ch_valid = 1'b1;
    ch_data  = d;
    chk("ready_before_send", 32'(ch_ready), 32'd1);
    @(posedge clk);
    #1;
    ch_valid = 1'b0;
    $display("tx byte=%02h col=%0d row=%0d cea=%0b ada=%0d din=%02h",
             d, cur_col, cur_row, v_cea, v_ada, v_din);
  endtask

  task automatic chk_write(input string name, input logic wr,
                           input logic [9:0] addr, input logic [7:0] din);
    chk({name, "_cea"}, 32'(v_cea), 32'(wr));
    if (wr) begin
      chk({name, "_ada"}, 32'(v_ada), 32'(addr));
      chk({name, "_din"}, 32'(v_din), 32'(din));
    end
  endtask

  task automatic apply_vec(input int i);
    send(vecs[i].data);
    chk_write($sformatf("vec%0d", i), vecs[i].wr, vecs[i].addr, vecs[i].din);
    chk($sformatf("vec%0d_col", i), 32'(cur_col), 32'(vecs[i].col));
    chk($sformatf("vec%0d_row", i), 32'(cur_row), 32'(vecs[i].row));
  endtask

  // Expect n consecutive BLANK writes starting at addr, block stalled throughout
  task automatic expect_clear(input string name, input int start, input int n);
    int errs_before;
    errs_before = bad;
    for (int i = 0; i < n; i++) begin
      chk({name, "_ready_low"}, 32'(ch_ready), 32'd0);
      chk({name, "_busy"}, 32'(busy), 32'd1);
      @(posedge clk);
      #1;
      chk_write(name, 1'b1, 10'(start + i), 8'h20);
    end
    chk({name, "_ready_back"}, 32'(ch_ready), 32'd1);
    chk({name, "_busy_done"}, 32'(busy), 32'd0);
    $display("tx clear %s start=%0d n=%0d errors=%0d", name, start, n, bad - errs_before);
  endtask

  task automatic send_lf_and_clear(input int exp_row);
    send(8'h0A);
    chk("lf_no_write", 32'(v_cea), 32'd0);
    chk("lf_row", 32'(cur_row), 32'(exp_row));
    chk("lf_col", 32'(cur_col), 32'd0);
    expect_clear($sformatf("row%0d", exp_row), exp_row * 60, 60);
  endtask

  initial begin
    vecs[0] = '{8'h41, 1'b1, 10'd0,   8'h41, 6'd1, 5'd0};
    vecs[1] = '{8'h42, 1'b1, 10'd1,   8'h42, 6'd2, 5'd0};
    vecs[2] = '{8'h0D, 1'b0, 10'd0,   8'h00, 6'd0, 5'd0};
    vecs[3] = '{8'h08, 1'b0, 10'd0,   8'h00, 6'd0, 5'd0};
    vecs[4] = '{8'h61, 1'b1, 10'd120, 8'h61, 6'd1, 5'd2};
    vecs[5] = '{8'h62, 1'b1, 10'd121, 8'h62, 6'd2, 5'd2};
    vecs[6] = '{8'h63, 1'b1, 10'd122, 8'h63, 6'd3, 5'd2};
    vecs[7] = '{8'h08, 1'b1, 10'd122, 8'h20, 6'd2, 5'd2};

    rst_n    = 1'b0;
    ch_valid = 1'b0;
    ch_data  = 8'h00;
    clr_req  = 1'b0;
    #1;
    chk("rst_cea", 32'(v_cea), 32'd0);
    chk("rst_ada", 32'(v_ada), 32'd0);
    chk("rst_din", 32'(v_din), 32'd0);
    chk("rst_col", 32'(cur_col), 32'd0);
    chk("rst_row", 32'(cur_row), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_ready", 32'(ch_ready), 32'd1);

    // 'A','B', CR, BS at column 0
    for (int i = 0; i < 4; i++) apply_vec(i);

    // Fill row 0, wrap into row 1 and its clear
    for (int i = 0; i < 60; i++) begin
      send(8'h30);
      chk_write($sformatf("fill%0d", i), 1'b1, 10'(i), 8'h30);
    end
    chk("fill_row", 32'(cur_row), 32'd1);
    chk("fill_col", 32'(cur_col), 32'd0);
    expect_clear("wrap_row1", 60, 60);

    // Row 2, col 3 then backspace
    send_lf_and_clear(2);
    for (int i = 4; i < 8; i++) apply_vec(i);

    // Move to col 40 then CR
    for (int i = 0; i < 38; i++) begin
      send(8'h2E);
      chk_write($sformatf("dot%0d", i), 1'b1, 10'(122 + i), 8'h2E);
    end
    chk("col40", 32'(cur_col), 32'd40);
    send(8'h0D);
    chk("cr_no_write", 32'(v_cea), 32'd0);
    chk("cr_col", 32'(cur_col), 32'd0);
    chk("cr_row", 32'(cur_row), 32'd2);

    // Walk down to row 16, col 5, then LF wraps to row 0
    for (int r = 3; r <= 16; r++) send_lf_and_clear(r);
    for (int i = 0; i < 5; i++) begin
      send(8'h45);
      chk_write($sformatf("r16c%0d", i), 1'b1, 10'(960 + i), 8'h45);
    end
    chk("r16_col", 32'(cur_col), 32'd5);
    send_lf_and_clear(0);

    // clr_req during the 30th cycle of a row clear, byte pending
    send(8'h0A);
    for (int i = 0; i < 29; i++) begin
      @(posedge clk);
      #1;
      chk_write("abort_pre", 1'b1, 10'(60 + i), 8'h20);
    end
    @(negedge clk);
    clr_req  = 1'b1;
    ch_valid = 1'b1;
    ch_data  = 8'h55;
    chk("clr_ready_low", 32'(ch_ready), 32'd0);
    @(posedge clk);
    #1;
    clr_req = 1'b0;
    chk("clr_trigger_no_write", 32'(v_cea), 32'd0);
    chk("clr_busy", 32'(busy), 32'd1);
    expect_clear("clr_all", 0, 1020);
    chk("clr_col", 32'(cur_col), 32'd0);
    chk("clr_row", 32'(cur_row), 32'd0);
    // The held byte is accepted on the first idle edge
    @(posedge clk);
    #1;
    ch_valid = 1'b0;
    chk_write("held_byte", 1'b1, 10'd0, 8'h55);
    chk("held_col", 32'(cur_col), 32'd1);
    $display("tx held byte=55 col=%0d row=%0d", cur_col, cur_row);

    // Reset in the middle of a full clear
    @(negedge clk);
    clr_req = 1'b1;
    @(negedge clk);
    clr_req = 1'b0;
    repeat (10) @(negedge clk);
    chk("midclr_cea", 32'(v_cea), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("midrst_cea", 32'(v_cea), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_col", 32'(cur_col), 32'd0);
    chk("midrst_ada", 32'(v_ada), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_ready", 32'(ch_ready), 32'd1);
    $display("tx reset mid clear");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/vram_console_writer.md
Name: vram_console_writer

Overview:
- Character-stream front end that writes text into the VRAM write port (v_ada/v_cea/v_din) read by the LCD controller.
- Accepts bytes over a valid/ready handshake, keeps a text cursor on a 60x17 grid (480x272, 8x16 glyphs) and emits single-cycle VRAM writes.
- Handles CR, LF and BS, wraps lines and rows, and blanks rows and the whole screen.
- Sits in the MEMORY_CLK domain alongside the CPU, as an alternative VRAM writer for console or debug text.

Parameters:
- COLS, 60, characters per row.
- ROWS, 17, rows per screen; COLS*ROWS must be at most 2**ADDR_W.
- ADDR_W, 10, VRAM address width.
- BLANK, 8'h20, fill code used for clearing.

Ports:
- clk  in  1  MEMORY_CLK-domain clock.
- rst_n  in  1  asynchronous active-low reset.
- ch_valid  in  1  ch_data holds a byte to write.
- ch_data  in  8  character code or control code.
- ch_ready  out  1  block can accept a byte this cycle.
- clr_req  in  1  single-cycle request to clear the screen.
- v_ada  out  ADDR_W  VRAM write address.
- v_cea  out  1  VRAM write enable, one cycle per write.
- v_din  out  8  VRAM write data.
- cur_col  out  6  cursor column, 0..COLS-1.
- cur_row  out  5  cursor row, 0..ROWS-1.
- busy  out  1  high while a clear sequence runs.

Behaviour:
- Clock and reset: one clock, clk. rst_n is asynchronous, active-low.
- Reset values: v_ada=0, v_din=0, v_cea=0, cur_col=0, cur_row=0, state IDLE, busy=0.
- v_ada, v_din and v_cea are registered. A write is presented the cycle after its cause. v_cea is never high for more than one cycle per address.
- Address: addr = row_base + col. row_base is a register that steps by COLS; no multiplier. The maximum address is COLS*ROWS-1 (1019).
- States:
  - IDLE: accepts bytes.
  - CLR_ROW: writes BLANK to COLS consecutive addresses of the current row.
  - CLR_ALL: writes BLANK to addresses 0..COLS*ROWS-1.
- ch_ready = (state==IDLE) && !clr_req, combinational. A byte transfers when ch_valid && ch_ready.
- Byte handling in IDLE:
  - 0x0D (CR): col=0. No write.
  - 0x0A (LF): newline.
  - 0x08 (BS): if col>0, then col=col-1 and BLANK is written at the new position. If col==0, no-op; no row underflow.
  - Any other code 0x00..0xFF (full font): written at addr, then col=col+1. If col was COLS-1, col=0 and newline.
- Newline: row=row+1, wrapping ROWS-1 -> 0, and row_base is updated. Then go to CLR_ROW for the new row. Cursor col=0.
- CLR_ROW: one write per cycle for COLS cycles (addresses row_base..row_base+COLS-1), then IDLE. ch_ready=0 and busy=1 throughout. The cycle that triggers the newline and its COLS clear writes make 1+COLS cycles before ch_ready returns.
- clr_req:
  - Accepted in any state, and takes priority over a simultaneous ch_valid. That byte is not accepted.
  - Aborts any CLR_ROW or CLR_ALL in progress and restarts CLR_ALL at address 0.
  - CLR_ALL takes COLS*ROWS cycles with one write per cycle. At completion the cursor is (0,0), row_base=0, state IDLE.
- busy = (state != IDLE).
- Reset asserted mid-sequence: all writes stop immediately (v_cea=0) and the cursor returns to (0,0). The VRAM contents are left partially written.
- Arithmetic: the col counter is 6 bits and the row counter 5 bits. Wrap compares against COLS-1 and ROWS-1, never against a power of two.

Optional Feature:
- Macro: CONSOLE_CLEAR_ON_RESET_EN.
- Defined: on reset release the block enters CLR_ALL instead of IDLE. busy=1 and ch_ready=0 for COLS*ROWS cycles, then IDLE with the cursor at (0,0).
- Undefined: the block leaves reset in IDLE with ch_ready=1. VRAM contents are untouched.

Test Plan:
- Reset, then send 'A','B' (0x41, 0x42) -> writes (0,0x41) then (1,0x42); cur_col=2; ch_ready stays 1.
- 60 bytes of 0x30 from col 0, row 0 -> addresses 0..59 written. Then 60 writes of 0x20 to 60..119. Final cursor (row=1, col=0). ch_ready low for exactly 60 cycles.
- Cursor at row 16 col 5, send 0x0A -> row=0 col=0, BLANK written to 0..59, no write at or above address 1020.
- At col 0, send 0x08 -> no write, cursor unchanged. At col 3 row 2, send 0x08 -> write (122,0x20), col=2. CR at col 40 -> col=0, no write.
- clr_req pulsed during the 30th cycle of a CLR_ROW, with ch_valid high at the same time -> byte not accepted. CLR_ALL writes 0..1019 (1020 cycles), cursor (0,0), busy falls, then the byte is accepted.
- With CONSOLE_CLEAR_ON_RESET_EN defined: release rst_n -> 1020 BLANK writes, ch_ready=0 until done. Assert rst_n=0 mid-clear -> v_cea=0 the same cycle, all outputs at reset values.
